// File: rtl/hist_eq_pkg.sv
// Shared constants, state encodings and helpers for the histogram-equalization engine.
package hist_eq_pkg;

  localparam int ADDR_W    = 16;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 17;
  localparam int DEPTH_W   = 17;
  localparam int NUM_BINS  = 256;
  localparam int HIST_BASE = 0;
  localparam int LUT_BASE  = 256;
  localparam int DIV_STEPS = 24;

  typedef logic [3:0] state_t;

  localparam state_t IDLE        = 4'd0;
  localparam state_t CLR         = 4'd1;
  localparam state_t HIST_RD_IN  = 4'd2;
  localparam state_t HIST_RD_BIN = 4'd3;
  localparam state_t HIST_WR     = 4'd4;
  localparam state_t LUT_RD      = 4'd5;
  localparam state_t LUT_DIV     = 4'd6;
  localparam state_t LUT_WR      = 4'd7;
  localparam state_t MAP_RD_IN   = 4'd8;
  localparam state_t MAP_RD_LUT  = 4'd9;
  localparam state_t MAP_WR      = 4'd10;
  localparam state_t DONE        = 4'd11;

  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d);
    return (d > 17'd65536) ? 17'd65536 : d;
  endfunction

endpackage

// File: rtl/hist_eq_sram.sv
// Single-port RAM: synchronous write, registered read with one cycle of latency.
module hist_eq_sram
  import hist_eq_pkg::*;
#(
  parameter int WIDTH = PIX_W,
  parameter int DEPTH = 1 << ADDR_W
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] Register [0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (we) Register[addr] <= wdata;
    rdata <= Register[addr];
  end

endmodule

// File: rtl/hist_eq_top.sv
// Histogram equalization: clear bins, count pixels, build CDF LUT with an inline divider, remap.
module hist_eq_top
  import hist_eq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [DEPTH_W-1:0] input_mem_depth,
  input  logic [DEPTH_W-1:0] scratch_mem_depth,
  input  logic [DEPTH_W-1:0] output_mem_depth,
  input  logic               new_image_pulse,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t             state;
  logic [DEPTH_W-1:0] n_len, m_len, idx;
  logic [7:0]         bin;
  logic [PIX_W-1:0]   pix;
  logic [CNT_W-1:0]   acc;
  logic [23:0]        quo;
  logic [CNT_W:0]     rem;
  logic [4:0]         div_cnt;

  logic              in_we, sc_we, out_we;
  logic [ADDR_W-1:0] in_addr, sc_addr, out_addr;
  logic [PIX_W-1:0]  in_wdata, in_rdata, out_wdata, out_rdata;
  logic [CNT_W-1:0]  sc_wdata, sc_rdata;

  logic [DEPTH_W-1:0] n_clamp, s_clamp, m_clamp, map_clamp;
  logic               cfg_err;
  logic [CNT_W-1:0]   acc_sum;
  logic [23:0]        dividend;
  logic [CNT_W:0]     rem_sh;
  logic               rem_ge;

  always_comb begin
    n_clamp   = clamp_depth(input_mem_depth);
    s_clamp   = clamp_depth(scratch_mem_depth);
    m_clamp   = clamp_depth(output_mem_depth);
    map_clamp = (m_clamp < n_clamp) ? m_clamp : n_clamp;
    cfg_err   = (n_clamp == '0) || (s_clamp < 17'd512);
    acc_sum   = acc + sc_rdata;
    dividend  = 24'(acc_sum) * 24'd255;
    // Restoring divider step: remainder shifted left, next dividend bit pulled from quo MSB.
    rem_sh    = {rem[CNT_W-1:0], quo[23]};
    rem_ge    = rem_sh >= {1'b0, n_len};
  end

  always_comb begin
    in_we     = 1'b0;
    in_wdata  = '0;
    in_addr   = idx[ADDR_W-1:0];
    sc_we     = 1'b0;
    sc_addr   = '0;
    sc_wdata  = '0;
    out_we    = 1'b0;
    out_addr  = idx[ADDR_W-1:0];
    out_wdata = sc_rdata[PIX_W-1:0];
    case (state)
      CLR: begin
        sc_we   = 1'b1;
        sc_addr = ADDR_W'(HIST_BASE) + ADDR_W'(bin);
      end
      HIST_RD_BIN: sc_addr = ADDR_W'(HIST_BASE) + ADDR_W'(in_rdata);
      HIST_WR: begin
        sc_we    = 1'b1;
        sc_addr  = ADDR_W'(HIST_BASE) + ADDR_W'(pix);
        sc_wdata = sc_rdata + 1'b1;
      end
      LUT_RD: sc_addr = ADDR_W'(HIST_BASE) + ADDR_W'(bin);
      LUT_WR: begin
        sc_we    = 1'b1;
        sc_addr  = ADDR_W'(LUT_BASE) + ADDR_W'(bin);
        sc_wdata = CNT_W'(quo[7:0]);
      end
      MAP_RD_LUT: sc_addr = ADDR_W'(LUT_BASE) + ADDR_W'(in_rdata);
      MAP_WR:     out_we  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      n_len   <= '0;
      m_len   <= '0;
      idx     <= '0;
      bin     <= '0;
      pix     <= '0;
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
      div_cnt <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (new_image_pulse == 1'b1) begin
          n_len <= n_clamp;
          m_len <= map_clamp;
          error <= cfg_err;
          idx   <= '0;
          bin   <= '0;
          acc   <= '0;
          state <= cfg_err ? DONE : CLR;
        end
        CLR: begin
          bin <= bin + 8'd1;
          if (bin == 8'hFF) state <= HIST_RD_IN;
        end
        HIST_RD_IN: state <= HIST_RD_BIN;
        HIST_RD_BIN: begin
          pix   <= in_rdata;
          state <= HIST_WR;
        end
        HIST_WR: begin
          if (idx == n_len - 1'b1) begin
            idx   <= '0;
            state <= LUT_RD;
          end else begin
            idx   <= idx + 1'b1;
            state <= HIST_RD_IN;
          end
        end
        LUT_RD: begin
          div_cnt <= '0;
          state   <= LUT_DIV;
        end
        LUT_DIV: begin
          // First cycle consumes the bin count; the next DIV_STEPS cycles run the divider.
          if (div_cnt == '0) begin
            acc     <= acc_sum;
            quo     <= dividend;
            rem     <= '0;
            div_cnt <= 5'd1;
          end else begin
            quo     <= {quo[22:0], rem_ge};
            rem     <= rem_ge ? rem_sh - {1'b0, n_len} : rem_sh;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'(DIV_STEPS)) state <= LUT_WR;
          end
        end
        LUT_WR: begin
          bin <= bin + 8'd1;
          if (bin == 8'hFF) state <= (m_len == '0) ? DONE : MAP_RD_IN;
          else              state <= LUT_RD;
        end
        MAP_RD_IN:  state <= MAP_RD_LUT;
        MAP_RD_LUT: state <= MAP_WR;
        MAP_WR: begin
          if (idx == m_len - 1'b1) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= MAP_RD_IN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  hist_eq_sram #(.WIDTH(PIX_W), .DEPTH(1 << ADDR_W)) input_memory_u0 (
    .clock (clock),
    .we    (in_we),
    .addr  (in_addr),
    .wdata (in_wdata),
    .rdata (in_rdata)
  );

  hist_eq_sram #(.WIDTH(CNT_W), .DEPTH(1 << ADDR_W)) scratch_memory_u0 (
    .clock (clock),
    .we    (sc_we),
    .addr  (sc_addr),
    .wdata (sc_wdata),
    .rdata (sc_rdata)
  );

  hist_eq_sram #(.WIDTH(PIX_W), .DEPTH(1 << ADDR_W)) output_memory_u0 (
    .clock (clock),
    .we    (out_we),
    .addr  (out_addr),
    .wdata (out_wdata),
    .rdata (out_rdata)
  );

endmodule

// File: tb/tb_hist_eq_top.sv
// Randomized and directed checks of hist_eq_top against an arithmetic histogram/CDF model.
module tb_hist_eq_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] input_mem_depth, scratch_mem_depth, output_mem_depth;
  logic        new_image_pulse;
  logic        busy, done, error;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [7:0] img     [0:1023];
  logic [7:0] out_pre [0:1023];

  always #5 clock = ~clock;

  hist_eq_top dut (
    .clock             (clock),
    .reset             (reset),
    .input_mem_depth   (input_mem_depth),
    .scratch_mem_depth (scratch_mem_depth),
    .output_mem_depth  (output_mem_depth),
    .new_image_pulse   (new_image_pulse),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  always @(posedge clock) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_mems(input int n);
    for (int i = 0; i < n; i++) dut.input_memory_u0.Register[i] = img[i];
    for (int i = 0; i < 1024; i++) begin
      out_pre[i] = 8'($urandom);
      dut.output_memory_u0.Register[i] = out_pre[i];
    end
  endtask

  task automatic run(input int n, input int m_cfg, input int sd, input bit poke);
    int cyc, bound, m, d0;
    m = (m_cfg > 65536) ? 65536 : m_cfg;
    if (m > n) m = n;
    bound = 256 + 3 * n + 28 * 256 + 3 * m + 4;
    @(negedge clock);
    d0 = done_cnt;
    input_mem_depth   = 17'(n);
    scratch_mem_depth = 17'(sd);
    output_mem_depth  = 17'(m_cfg);
    new_image_pulse   = 1'b1;
    @(negedge clock);
    new_image_pulse = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      if (busy === 1'b1) cyc++;
      new_image_pulse = (poke && cyc == 400) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    new_image_pulse = 1'b0;
    check("done_seen", {31'd0, done}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    check("error_clear", {31'd0, error}, 0);
    check("busy_bound", (cyc <= bound) ? 1 : 0, 1);
    repeat (3) @(negedge clock);
    check("one_done_pulse", done_cnt - d0, 1);
  endtask

  task automatic verify(input int n, input int m_cfg);
    int hist [256];
    int lut  [256];
    int cdf, m;
    m = (m_cfg > 65536) ? 65536 : m_cfg;
    if (m > n) m = n;
    for (int b = 0; b < 256; b++) hist[b] = 0;
    for (int i = 0; i < n; i++) hist[img[i]]++;
    cdf = 0;
    for (int b = 0; b < 256; b++) begin
      cdf += hist[b];
      lut[b] = (cdf * 255) / n;
    end
    for (int b = 0; b < 256; b++) begin
      check($sformatf("bin[%0d]", b), 32'(dut.scratch_memory_u0.Register[b]), hist[b]);
      check($sformatf("lut[%0d]", b), 32'(dut.scratch_memory_u0.Register[256 + b]), lut[b]);
    end
    for (int i = 0; i < m; i++)
      check($sformatf("out[%0d]", i), 32'(dut.output_memory_u0.Register[i]), lut[img[i]]);
    for (int i = m; i < m + 4 && i < 1024; i++)
      check($sformatf("out_kept[%0d]", i), 32'(dut.output_memory_u0.Register[i]), 32'(out_pre[i]));
  endtask

  task automatic err_run(input int n, input int sd);
    logic [16:0] snap [0:511];
    int seen;
    for (int i = 0; i < 512; i++) snap[i] = dut.scratch_memory_u0.Register[i];
    for (int i = 0; i < 1024; i++) begin
      out_pre[i] = 8'($urandom);
      dut.output_memory_u0.Register[i] = out_pre[i];
    end
    @(negedge clock);
    input_mem_depth   = 17'(n);
    scratch_mem_depth = 17'(sd);
    output_mem_depth  = 17'd16;
    new_image_pulse   = 1'b1;
    seen = 0;
    for (int k = 0; k < 3 && seen == 0; k++) begin
      @(negedge clock);
      new_image_pulse = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    check($sformatf("err_done_n%0d_s%0d", n, sd), seen, 1);
    check("err_flag", {31'd0, error}, 1);
    repeat (4) @(negedge clock);
    check("err_sticky", {31'd0, error}, 1);
    check("err_idle", {31'd0, busy}, 0);
    seen = 0;
    for (int i = 0; i < 512; i++) if (dut.scratch_memory_u0.Register[i] !== snap[i]) seen++;
    check("err_scratch_untouched", seen, 0);
    seen = 0;
    for (int i = 0; i < 1024; i++) if (dut.output_memory_u0.Register[i] !== out_pre[i]) seen++;
    check("err_output_untouched", seen, 0);
  endtask

  initial begin
    int n, m, d0;
    reset = 1'b1;
    new_image_pulse   = 1'b0;
    input_mem_depth   = '0;
    scratch_mem_depth = '0;
    output_mem_depth  = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    reset = 1'b0;

    // Small directed image with hand-computed results.
    img[0] = 8'h10; img[1] = 8'h10; img[2] = 8'h20; img[3] = 8'hFF;
    load_mems(4);
    run(4, 4, 1024, 1'b0);
    verify(4, 4);
    check("d4_out0", 32'(dut.output_memory_u0.Register[0]), 127);
    check("d4_out1", 32'(dut.output_memory_u0.Register[1]), 127);
    check("d4_out2", 32'(dut.output_memory_u0.Register[2]), 191);
    check("d4_out3", 32'(dut.output_memory_u0.Register[3]), 255);
    check("d4_bin10", 32'(dut.scratch_memory_u0.Register[16]), 2);

    // Ramp image gives an identity LUT; a second start lands mid-run and must be ignored.
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load_mems(256);
    run(256, 256, 512, 1'b1);
    verify(256, 256);
    for (int i = 0; i < 256; i += 51) check($sformatf("ramp[%0d]", i), 32'(dut.output_memory_u0.Register[i]), i);

    // Flat image.
    for (int i = 0; i < 8; i++) img[i] = 8'h42;
    load_mems(8);
    run(8, 8, 600, 1'b0);
    verify(8, 8);
    check("flat_bin", 32'(dut.scratch_memory_u0.Register[8'h42]), 8);
    check("flat_lut_lo", 32'(dut.scratch_memory_u0.Register[256 + 8'h41]), 0);
    check("flat_out", 32'(dut.output_memory_u0.Register[7]), 255);

    // Configuration errors, including the 511/512 scratch boundary.
    err_run(4, 100);
    err_run(0, 1024);
    err_run(4, 511);

    // Output depth shorter than the image.
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    load_mems(4);
    run(4, 2, 1024, 1'b0);
    verify(4, 2);

    // Reset during HIST aborts with no done pulse.
    for (int i = 0; i < 200; i++) img[i] = 8'($urandom_range(0, 63));
    load_mems(200);
    @(negedge clock);
    input_mem_depth   = 17'd200;
    scratch_mem_depth = 17'd512;
    output_mem_depth  = 17'd200;
    new_image_pulse   = 1'b1;
    @(negedge clock);
    new_image_pulse = 1'b0;
    repeat (300) @(negedge clock);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 0);
    run(200, 200, 512, 1'b0);
    verify(200, 200);

    // Random images; one with a clamped output depth, one with M=0.
    n = $urandom_range(1, 400);
    for (int i = 0; i < n; i++) img[i] = 8'($urandom);
    load_mems(n);
    run(n, 17'h1FFFF, 17'h1FFFF, 1'b0);
    verify(n, 65536);

    n = $urandom_range(1, 300);
    m = 0;
    for (int i = 0; i < n; i++) img[i] = 8'($urandom_range(100, 140));
    load_mems(n);
    run(n, m, 512, 1'b0);
    verify(n, m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
